// File: rtl/btb_ctrl.sv
// BTB sequencing controller: queues resolved branch updates, drains them into
// the BTB write port, gates prediction, and runs the flush/invalidate handshake.
module btb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_valid,
  input  logic [31:0]            res_pc,
  input  logic [31:0]            res_target,
  output logic                   res_ready,
  input  logic                   hold,
  input  logic                   fetch_req,
  input  logic                   flush_req,
  output logic                   flush_ack,
  output logic                   btb_predict,
  output logic                   btb_update,
  output logic [31:0]            btb_pc_exec,
  output logic [31:0]            btb_alu_out,
  output logic                   btb_clear,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, ACK} state_t;

  state_t        state;
  logic [31:0]   mem_pc  [DEPTH];
  logic [31:0]   mem_tgt [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, newest_ptr;
  logic [AW:0]   count;
  logic [31:0]   last_pc, last_tgt;
  logic          last_vld;
  logic          empty, full, dup_newest, dup_last, accept, enq, deq;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign newest_ptr = wr_ptr - AW'(1);

  // A duplicate of the newest queued entry or of the entry just written is
  // consumed (handshake completes) but never reaches the BTB a second time.
  assign dup_newest = !empty && (mem_pc[newest_ptr] == res_pc) && (mem_tgt[newest_ptr] == res_target);
  assign dup_last   = last_vld && (last_pc == res_pc) && (last_tgt == res_target);

  assign res_ready   = (state == IDLE) && !full && !flush_req;
  assign btb_update  = (state == IDLE) && !empty && !hold && !flush_req;
  assign btb_predict = fetch_req && (state == IDLE);
  assign btb_pc_exec = empty ? '0 : mem_pc[rd_ptr];
  assign btb_alu_out = empty ? '0 : mem_tgt[rd_ptr];
  assign pending     = count;

  assign accept = res_valid && res_ready;
  assign enq    = accept && !dup_newest && !dup_last;
  assign deq    = btb_update;

  // NOTE: the payload array has no reset; occupancy is tracked by count and
  // the outputs are masked when empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr]  <= res_pc;
      mem_tgt[wr_ptr] <= res_target;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_pc   <= '0;
      last_tgt  <= '0;
      last_vld  <= 1'b0;
      flush_ack <= 1'b0;
      btb_clear <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state     <= CLEAR;
            btb_clear <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_vld  <= 1'b0;
          end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) begin
              rd_ptr   <= rd_ptr + AW'(1);
              last_pc  <= mem_pc[rd_ptr];
              last_tgt <= mem_tgt[rd_ptr];
              last_vld <= 1'b1;
            end
            count <= count + (AW+1)'(enq) - (AW+1)'(deq);
          end
        end
        CLEAR: begin
          state     <= ACK;
          btb_clear <= 1'b0;
          flush_ack <= 1'b1;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          count     <= '0;
          last_vld  <= 1'b0;
        end
        ACK: begin
          state     <= IDLE;
          flush_ack <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          btb_clear <= 1'b0;
          flush_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: hand-computed vectors checked with immediate
// assertions, inputs changed 1 ns after the rising edge.
module tb_btb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_pc, res_target;
  logic        res_ready;
  logic        hold, fetch_req, flush_req;
  logic        flush_ack, btb_predict, btb_update, btb_clear;
  logic [31:0] btb_pc_exec, btb_alu_out;
  logic [2:0]  pending;

  int n_vec = 0;
  int n_err = 0;

  btb_ctrl #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_target  (res_target),
    .res_ready   (res_ready),
    .hold        (hold),
    .fetch_req   (fetch_req),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .btb_predict (btb_predict),
    .btb_update  (btb_update),
    .btb_pc_exec (btb_pc_exec),
    .btb_alu_out (btb_alu_out),
    .btb_clear   (btb_clear),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_target = '0;
    hold = 1'b0; fetch_req = 1'b1; flush_req = 1'b0;
    #2;
    check("rst_pending",  32'(pending), 32'd0);
    check("rst_update",   32'(btb_update), 32'd0);
    check("rst_ack",      32'(flush_ack), 32'd0);
    check("rst_clear",    32'(btb_clear), 32'd0);
    check("rst_pc",       btb_pc_exec, 32'h0);
    check("rst_tgt",      btb_alu_out, 32'h0);
    check("rst_ready",    32'(res_ready), 32'd1);
    check("rst_predict",  32'(btb_predict), 32'd1);
    flush_req = 1'b1; #1;
    check("rst_ready_fl", 32'(res_ready), 32'd0);
    flush_req = 1'b0; fetch_req = 1'b0; #1;
    check("rst_predict0", 32'(btb_predict), 32'd0);
    #8 rst = 1'b0;
    cyc();

    // single update
    res_valid = 1'b1; res_pc = 32'h100; res_target = 32'h200; #1;
    check("s_ready", 32'(res_ready), 32'd1);
    cyc();
    res_valid = 1'b0; #1;
    check("s_pend1",  32'(pending), 32'd1);
    check("s_update", 32'(btb_update), 32'd1);
    check("s_pc",     btb_pc_exec, 32'h100);
    check("s_tgt",    btb_alu_out, 32'h200);
    check("s_ready2", 32'(res_ready), 32'd1);
    cyc();
    check("s_pend0",  32'(pending), 32'd0);
    check("s_upd0",   32'(btb_update), 32'd0);
    check("s_pc0",    btb_pc_exec, 32'h0);

    // fill under hold
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_pc = 32'h1000 + 32'(i*4); res_target = 32'h2000 + 32'(i*16); #1;
      check("f_ready", 32'(res_ready), (i < 4) ? 32'd1 : 32'd0);
      check("f_upd",   32'(btb_update), 32'd0);
      cyc();
    end
    res_valid = 1'b0; #1;
    check("f_pend4",  32'(pending), 32'd4);
    check("f_full",   32'(res_ready), 32'd0);
    hold = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("d_upd", 32'(btb_update), 32'd1);
      check("d_pc",  btb_pc_exec, 32'h1000 + 32'(i*4));
      check("d_tgt", btb_alu_out, 32'h2000 + 32'(i*16));
      cyc();
    end
    check("d_upd0",  32'(btb_update), 32'd0);
    check("d_pend0", 32'(pending), 32'd0);
    check("d_ready", 32'(res_ready), 32'd1);

    // dedup: back-to-back duplicate
    res_valid = 1'b1; res_pc = 32'h500; res_target = 32'h600;
    cyc();
    check("dd_pend1", 32'(pending), 32'd1);
    check("dd_upd",   32'(btb_update), 32'd1);
    check("dd_ready", 32'(res_ready), 32'd1);
    cyc();
    check("dd_pend0", 32'(pending), 32'd0);
    check("dd_upd0",  32'(btb_update), 32'd0);
    // resend after drain: dropped via last-written register
    cyc();
    check("dl_pend0", 32'(pending), 32'd0);
    check("dl_upd0",  32'(btb_update), 32'd0);
    // same pc, new target: enqueued
    res_target = 32'h700;
    cyc();
    res_valid = 1'b0; #1;
    check("dt_pend1", 32'(pending), 32'd1);
    check("dt_upd",   32'(btb_update), 32'd1);
    check("dt_tgt",   btb_alu_out, 32'h700);
    cyc();
    check("dt_pend0", 32'(pending), 32'd0);

    // flush with pending entries
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_pc = 32'h3000 + 32'(i*4); res_target = 32'h4000 + 32'(i*4);
      cyc();
    end
    res_valid = 1'b0; #1;
    check("fl_pend3", 32'(pending), 32'd3);
    flush_req = 1'b1; #1;
    check("fl_ready", 32'(res_ready), 32'd0);
    check("fl_upd_c", 32'(btb_update), 32'd0);
    cyc();
    hold = 1'b0; #1;
    check("fl_clear", 32'(btb_clear), 32'd1);
    check("fl_ack_c1", 32'(flush_ack), 32'd0);
    check("fl_upd_c1", 32'(btb_update), 32'd0);
    cyc();
    check("fl_ack",    32'(flush_ack), 32'd1);
    check("fl_clear0", 32'(btb_clear), 32'd0);
    check("fl_pend0",  32'(pending), 32'd0);
    check("fl_upd_c2", 32'(btb_update), 32'd0);
    check("fl_pc0",    btb_pc_exec, 32'h0);
    flush_req = 1'b0;
    cyc();
    check("fl_ack0",   32'(flush_ack), 32'd0);
    check("fl_upd_c3", 32'(btb_update), 32'd0);
    check("fl_ready3", 32'(res_ready), 32'd1);

    // simultaneous flush and update
    fetch_req = 1'b1;
    res_valid = 1'b1; res_pc = 32'h900; res_target = 32'hA00; flush_req = 1'b1; #1;
    check("sf_ready", 32'(res_ready), 32'd0);
    check("sf_pred",  32'(btb_predict), 32'd1);
    cyc();
    res_valid = 1'b0; #1;
    check("sf_clear", 32'(btb_clear), 32'd1);
    check("sf_pred_c", 32'(btb_predict), 32'd0);
    cyc();
    check("sf_ack",    32'(flush_ack), 32'd1);
    check("sf_pred_a", 32'(btb_predict), 32'd0);
    flush_req = 1'b0;
    cyc();
    check("sf_pend0", 32'(pending), 32'd0);
    check("sf_upd0",  32'(btb_update), 32'd0);
    check("sf_pred_i", 32'(btb_predict), 32'd1);

    // async reset mid-flush
    hold = 1'b1;
    res_valid = 1'b1; res_pc = 32'hB00; res_target = 32'hC00;
    cyc();
    res_valid = 1'b0; #1;
    check("ar_pend1", 32'(pending), 32'd1);
    flush_req = 1'b1;
    cyc();
    check("ar_clear1", 32'(btb_clear), 32'd1);
    #2 flush_req = 1'b0; hold = 1'b0; rst = 1'b1; #1;
    check("ar_clear", 32'(btb_clear), 32'd0);
    check("ar_ack",   32'(flush_ack), 32'd0);
    check("ar_pend",  32'(pending), 32'd0);
    check("ar_upd",   32'(btb_update), 32'd0);
    check("ar_pc",    btb_pc_exec, 32'h0);
    check("ar_ready", 32'(res_ready), 32'd1);
    check("ar_pred",  32'(btb_predict), 32'd1);
    #3 rst = 1'b0;
    cyc();
    check("ar_ack_n",  32'(flush_ack), 32'd0);
    check("ar_ready_n", 32'(res_ready), 32'd1);
    cyc();
    check("ar_ack_n2", 32'(flush_ack), 32'd0);
    check("ar_pend_n", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
